// File: rtl/rv32i_dmem_responder_pkg.sv
// Shared constants, FSM encoding and address-range helper for the data-memory responder.
package rv32i_dmem_responder_pkg;

   localparam int MEM_ADDR_W      = 32;
   localparam int MEM_DATA_W      = 32;
   localparam int MEM_BE_W        = 4;
   localparam int WAIT_CYCLES_MIN = 1;
   localparam int WAIT_CYCLES_MAX = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_t;

   // True when addr falls inside [base, base + span_bytes).
   function automatic logic addr_in_range(input logic [MEM_ADDR_W-1:0] addr,
                                          input logic [MEM_ADDR_W-1:0] base,
                                          input logic [63:0]           span_bytes);
      logic [MEM_ADDR_W-1:0] off;
      off = addr - base;
      return (addr >= base) && ({32'd0, off} < span_bytes);
   endfunction

endpackage

// File: rtl/rv32i_dmem_responder_array.sv
// Word storage: one synchronous read port, one byte-enabled write port, no reset.
module rv32i_dmem_array #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           rd_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
   output logic [31:0]                    rd_data,
   input  logic                           wr_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
   input  logic [3:0]                     wr_be,
   input  logic [31:0]                    wr_data
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rd_data_reg;

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data_reg <= mem[rd_idx];
      end
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
               mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
         end
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Fixed-latency data-memory responder for the MW stage: stalls the core for
// WAIT_CYCLES cycles per access, then completes the load or store in one RESP cycle.
module rv32i_dmem_responder
   import rv32i_dmem_responder_pkg::*;
#(
   parameter int              WAIT_CYCLES = 2,
   parameter int              DEPTH_WORDS = 1024,
   parameter logic [31:0]     BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_byte_en,
   input  logic        dmem_wr_en,
   input  logic        dmem_rd_en,
   output logic [31:0] dmem_rdata,
   output logic        stall_out,
   output logic        access_fault
);

   localparam int          AW       = $clog2(DEPTH_WORDS);
   localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) * 64'd4;
   localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES >= 2) ? 4'(WAIT_CYCLES - 2) : 4'd0;

   dmem_state_t  state_reg;
   logic [3:0]   cnt_reg;
   logic [AW-1:0] idx_reg;
   logic [31:0]  wdata_reg;
   logic [3:0]   be_reg;
   logic         in_range_reg;
   logic         is_store_reg;
   logic         is_load_reg;
   logic         fault_reg;
   logic         load_ok_reg;

   logic          req;
   logic          req_in_range;
   logic [31:0]   req_off;
   logic [AW-1:0] req_idx;
   logic          enter_resp;
   logic [AW-1:0] rd_idx;
   logic          mem_wr_en;
   logic [31:0]   mem_rd_data;

   assign req          = dmem_rd_en | dmem_wr_en;
   assign req_in_range = addr_in_range(dmem_addr, BASE_ADDR, SPAN);
   assign req_off      = dmem_addr - BASE_ADDR;
   assign req_idx      = req_off[AW+1:2];

   // The array's read register is loaded on the edge that enters RESP; with a
   // single wait cycle that edge is also the acceptance edge, so read the live address.
   assign enter_resp = !rst && (((state_reg == ST_IDLE) && req && (WAIT_CYCLES == 1)) ||
                                ((state_reg == ST_WAIT) && (cnt_reg == 4'd0)));
   assign rd_idx     = (state_reg == ST_IDLE) ? req_idx : idx_reg;
   assign mem_wr_en  = !rst && (state_reg == ST_RESP) && is_store_reg && in_range_reg;

   rv32i_dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk     (clk),
      .rd_en   (enter_resp),
      .rd_idx  (rd_idx),
      .rd_data (mem_rd_data),
      .wr_en   (mem_wr_en),
      .wr_idx  (idx_reg),
      .wr_be   (be_reg),
      .wr_data (wdata_reg)
   );

   always_ff @(posedge clk) begin
      if ((state_reg == ST_IDLE) && req) begin
         idx_reg      <= req_idx;
         wdata_reg    <= dmem_wdata;
         be_reg       <= dmem_byte_en;
         in_range_reg <= req_in_range;
         is_store_reg <= dmem_wr_en;
         is_load_reg  <= dmem_rd_en;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= 4'd0;
         fault_reg   <= 1'b0;
         load_ok_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               fault_reg   <= 1'b0;
               load_ok_reg <= 1'b0;
               if (req) begin
                  if (WAIT_CYCLES == 1) begin
                     state_reg   <= ST_RESP;
                     fault_reg   <= !req_in_range;
                     load_ok_reg <= dmem_rd_en && req_in_range;
                  end else begin
                     state_reg <= ST_WAIT;
                     cnt_reg   <= CNT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_reg == 4'd0) begin
                  state_reg   <= ST_RESP;
                  fault_reg   <= !in_range_reg;
                  load_ok_reg <= is_load_reg && in_range_reg;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            ST_RESP: begin
               state_reg   <= ST_IDLE;
               fault_reg   <= 1'b0;
               load_ok_reg <= 1'b0;
            end
            default: begin
               state_reg   <= ST_IDLE;
               fault_reg   <= 1'b0;
               load_ok_reg <= 1'b0;
            end
         endcase
      end
   end

   // A store that also asserts rd_en returns the pre-store word; a plain store returns 0.
   assign stall_out    = ((state_reg == ST_IDLE) && req) || (state_reg == ST_WAIT);
   assign dmem_rdata   = load_ok_reg ? mem_rd_data : 32'd0;
   assign access_fault = fault_reg;

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed bench for rv32i_dmem_responder: one instance with 2 wait cycles, one with 1.
module tb_rv32i_dmem_responder;

   logic        clk = 1'b0;
   logic [1:0]  rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [1:0]  wr_en;
   logic [1:0]  rd_en;
   logic [31:0] rdata [2];
   logic [1:0]  stall;
   logic [1:0]  fault;

   int checks = 0;
   int errors = 0;
   int wc [2] = '{2, 1};

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        fault;
      int          stalls;
   } exp_t;
   exp_t sb [$];

   always #5 clk = ~clk;

   rv32i_dmem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(64), .BASE_ADDR(32'h0)) dut_w2 (
      .clk(clk), .rst(rst[0]), .dmem_addr(addr), .dmem_wdata(wdata), .dmem_byte_en(be),
      .dmem_wr_en(wr_en[0]), .dmem_rd_en(rd_en[0]), .dmem_rdata(rdata[0]),
      .stall_out(stall[0]), .access_fault(fault[0])
   );

   rv32i_dmem_responder #(.WAIT_CYCLES(1), .DEPTH_WORDS(16), .BASE_ADDR(32'h0)) dut_w1 (
      .clk(clk), .rst(rst[1]), .dmem_addr(addr), .dmem_wdata(wdata), .dmem_byte_en(be),
      .dmem_wr_en(wr_en[1]), .dmem_rd_en(rd_en[1]), .dmem_rdata(rdata[1]),
      .stall_out(stall[1]), .access_fault(fault[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input int d, input string tag);
      chk({tag, "_stall"}, {31'd0, stall[d]}, 32'd0);
      chk({tag, "_rdata"}, rdata[d], 32'd0);
      chk({tag, "_fault"}, {31'd0, fault[d]}, 32'd0);
   endtask

   // Entered and left at posedge+1; drives one request, counts stall cycles, checks RESP.
   task automatic access(input int d, input string tag, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b, input bit wr,
                         input bit rd, input logic [31:0] exp_rd, input bit exp_fault,
                         input bit hold);
      exp_t e;
      int   stalls;
      bit   done;
      addr = a; wdata = wd; be = b; wr_en[d] = wr; rd_en[d] = rd;
      e.tag = tag; e.rdata = exp_rd; e.fault = exp_fault; e.stalls = wc[d];
      sb.push_back(e);
      stalls = 0;
      done   = 1'b0;
      #1;
      for (int i = 0; i < 40 && !done; i++) begin
         if (stall[d]) begin
            stalls++;
            @(posedge clk); #2;
         end else begin
            done = 1'b1;
         end
      end
      if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
      e = sb.pop_front();
      chk({e.tag, "_stalls"}, 32'(stalls), 32'(e.stalls));
      chk({e.tag, "_rdata"}, rdata[d], e.rdata);
      chk({e.tag, "_fault"}, {31'd0, fault[d]}, {31'd0, e.fault});
      if (!hold) begin
         wr_en[d] = 1'b0;
         rd_en[d] = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 2'b11; addr = '0; wdata = '0; be = '0; wr_en = '0; rd_en = '0;
      repeat (2) @(posedge clk);
      #1;
      idle_chk(0, "reset_w2");
      idle_chk(1, "reset_w1");
      rst = 2'b00;

      // Two wait cycles: full word, byte lanes, empty enables, store-with-read.
      access(0, "st10",    32'h10, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0,        0, 0);
      idle_chk(0, "idle_after_st");
      access(0, "ld10",    32'h10, 32'h0,        4'h0, 0, 1, 32'hDEADBEEF, 0, 0);
      idle_chk(0, "idle_after_ld");
      access(0, "st20",    32'h20, 32'h11223344, 4'hF, 1, 0, 32'h0,        0, 0);
      access(0, "st20b2",  32'h20, 32'h00AA0000, 4'h4, 1, 0, 32'h0,        0, 0);
      access(0, "ld20",    32'h20, 32'h0,        4'h0, 0, 1, 32'h11AA3344, 0, 0);
      access(0, "st20be0", 32'h20, 32'hFFFFFFFF, 4'h0, 1, 0, 32'h0,        0, 0);
      access(0, "ld20u",   32'h20, 32'h0,        4'h0, 0, 1, 32'h11AA3344, 0, 0);
      access(0, "rw20",    32'h20, 32'h55667788, 4'hF, 1, 1, 32'h11AA3344, 0, 0);
      access(0, "ld20n",   32'h20, 32'h0,        4'h0, 0, 1, 32'h55667788, 0, 0);
      access(0, "ld13",    32'h13, 32'h0,        4'h0, 0, 1, 32'hDEADBEEF, 0, 0);

      // Range boundary: last word is legal, the next byte address faults.
      access(0, "st00",    32'h00, 32'h12345678, 4'hF, 1, 0, 32'h0,        0, 0);
      access(0, "stFC",    32'hFC, 32'hCAFEF00D, 4'hF, 1, 0, 32'h0,        0, 0);
      access(0, "ldFC",    32'hFC, 32'h0,        4'h0, 0, 1, 32'hCAFEF00D, 0, 0);
      access(0, "ld100",   32'h100, 32'h0,       4'h0, 0, 1, 32'h0,        1, 0);
      idle_chk(0, "fault_one_cycle");
      access(0, "st100",   32'h100, 32'hBADBAD00, 4'hF, 1, 0, 32'h0,       1, 0);
      access(0, "ld00",    32'h00, 32'h0,        4'h0, 0, 1, 32'h12345678, 0, 0);
      access(0, "ldFC2",   32'hFC, 32'h0,        4'h0, 0, 1, 32'hCAFEF00D, 0, 0);

      // Reset during the WAIT cycle of a store abandons it.
      access(0, "st08",    32'h08, 32'h00000005, 4'hF, 1, 0, 32'h0,        0, 0);
      addr = 32'h08; wdata = 32'hFFFFFFFF; be = 4'hF; wr_en[0] = 1'b1;
      #1;
      chk("rst_idle_stall", {31'd0, stall[0]}, 32'd1);
      @(posedge clk); #1;
      chk("rst_wait_stall", {31'd0, stall[0]}, 32'd1);
      rst[0] = 1'b1; wr_en[0] = 1'b0;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      idle_chk(0, "after_rst");
      @(posedge clk); #1;
      access(0, "ld08",    32'h08, 32'h0,        4'h0, 0, 1, 32'h00000005, 0, 0);

      // One wait cycle: back-to-back loads, each served once.
      access(1, "w1_st0",  32'h0, 32'h00000001, 4'hF, 1, 0, 32'h0,         0, 0);
      access(1, "w1_st4",  32'h4, 32'h00000002, 4'hF, 1, 0, 32'h0,         0, 0);
      access(1, "w1_ld0",  32'h0, 32'h0,        4'h0, 0, 1, 32'h00000001,  0, 1);
      access(1, "w1_ld4",  32'h4, 32'h0,        4'h0, 0, 1, 32'h00000002,  0, 1);
      access(1, "w1_ld4r", 32'h4, 32'h0,        4'h0, 0, 1, 32'h00000002,  0, 0);
      idle_chk(1, "w1_idle_a");
      @(posedge clk); #1;
      idle_chk(1, "w1_idle_b");
      access(1, "w1_ld40", 32'h40, 32'h0,       4'h0, 0, 1, 32'h0,         1, 0);
      idle_chk(1, "w1_idle_c");

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
